// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared types and helpers for the pipelined carry-lookahead adder.
//   op_e       : operation select (OP_ADD = 0, OP_SUB = 1)
//   stages()   : number of pipeline stages for a width/group/groups-per-stage
//   widthOk()  : elaboration-time legality check of the geometry
//   lookahead(): flat sum-of-products carry into position n of a P/G vector
// -----------------------------------------------------------------------------
package cla_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Widest P/G vector the lookahead helper handles; callers zero-extend.
    localparam int LA_MAX = 64;

    function automatic int stages(input int width, input int group, input int gps);
        return width / (group * gps);
    endfunction

    function automatic bit widthOk(input int width, input int group, input int gps);
        return (group > 0) && (gps > 0) && (group <= LA_MAX) && (gps <= LA_MAX) &&
               (width >= group * gps) && ((width % (group * gps)) == 0);
    endfunction

    // Carry into position n written as an explicit OR of AND terms
    // (g[m] & p[m+1..n-1], plus cin & p[0..n-1]) so no carry ripples.
    function automatic logic lookahead(input logic [LA_MAX-1:0] p,
                                       input logic [LA_MAX-1:0] g,
                                       input logic cin,
                                       input int n);
        logic carry;
        logic term;
        carry = cin;
        for (int j = 0; j < n; j++) begin
            carry = carry & p[j];
        end
        for (int m = 0; m < n; m++) begin
            term = g[m];
            for (int j = m + 1; j < n; j++) begin
                term = term & p[j];
            end
            carry = carry | term;
        end
        return carry;
    endfunction

endpackage

// File: rtl/cla_group.sv
// -----------------------------------------------------------------------------
// cla_group
// GROUP-bit carry-lookahead adder cell. Every internal carry comes straight
// from the lookahead equations; the group propagate/generate let an outer
// level compute this group's carry-in without waiting for the sum.
//   a_i, b_i : operand bits (b_i already inverted for subtraction)
//   cin_i    : carry into bit 0 of the group
//   sum_o    : group sum bits
//   p_o, g_o : group propagate / generate
// -----------------------------------------------------------------------------
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             cin_i,
    output logic [GROUP-1:0] sum_o,
    output logic             p_o,
    output logic             g_o
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Carry into each bit position, resolved in parallel from cin and P/G.
    always_comb begin
        c = '0;
        for (int i = 0; i < GROUP; i++) begin
            c[i] = lookahead(LA_MAX'(p), LA_MAX'(g), cin_i, i);
        end
    end

    assign sum_o = p ^ c;
    assign p_o   = &p;
    assign g_o   = lookahead(LA_MAX'(p), LA_MAX'(g), 1'b0, GROUP);

endmodule

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage k resolves bits [k*SW +: SW] from the carry registered by stage k-1;
// operands ride along with each beat until consumed and finished sum slices
// are carried forward so the full result lines up in the last stage register.
// Accepted beat appears at the output STAGES edges after acceptance (counting
// the accept edge); one beat per clock when the consumer keeps up.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake
//   in_a, in_b, in_c_in   : operands and carry-in (carry-in ignored for SUB)
//   in_op                 : OP_ADD or OP_SUB
//   out_valid / out_ready : result handshake
//   out_sum, out_c_out    : result modulo 2^WIDTH, carry out of MSB
//   out_ovf               : two's-complement signed overflow
// -----------------------------------------------------------------------------
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int GROUP            = 4,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c_in,
    input  op_e              in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c_out,
    output logic             out_ovf
);

    localparam int SW     = GROUP * GROUPS_PER_STAGE;
    localparam int STAGES = stages(WIDTH, GROUP, GROUPS_PER_STAGE);

    if (!widthOk(WIDTH, GROUP, GROUPS_PER_STAGE)) begin : gBadGeometry
        $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP*GROUPS_PER_STAGE");
    end

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] carry_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  opA_q [STAGES];
    logic [WIDTH-1:0]  opA_d [STAGES];
    logic [WIDTH-1:0]  opB_q [STAGES];
    logic [WIDTH-1:0]  opB_d [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];

    // Per-stage datapath: pick the stage inputs, resolve one SW-bit slice
    // with group lookahead, and present the next contents of the stage register.
    for (genvar k = 0; k < STAGES; k++) begin : gStage
        logic [WIDTH-1:0]            srcA;
        logic [WIDTH-1:0]            srcB;
        logic [WIDTH-1:0]            srcSum;
        logic [WIDTH-1:0]            nextSum;
        logic                        srcCin;
        logic [GROUPS_PER_STAGE-1:0] grpP;
        logic [GROUPS_PER_STAGE-1:0] grpG;
        logic [GROUPS_PER_STAGE:0]   grpC;
        logic [SW-1:0]               sliceSum;

        // Subtraction is a + ~b + 1, so the mode is folded in once at entry
        // and later stages only ever add.
        if (k == 0) begin : gFirst
            assign srcA   = in_a;
            assign srcB   = (in_op == OP_SUB) ? ~in_b : in_b;
            assign srcCin = (in_op == OP_SUB) ? 1'b1 : in_c_in;
            assign srcSum = '0;
        end else begin : gLater
            assign srcA   = opA_q[k-1];
            assign srcB   = opB_q[k-1];
            assign srcCin = carry_q[k-1];
            assign srcSum = sum_q[k-1];
        end

        // Group carry-ins for this slice, derived together from group P/G.
        always_comb begin
            grpC = '0;
            for (int j = 0; j <= GROUPS_PER_STAGE; j++) begin
                grpC[j] = lookahead(LA_MAX'(grpP), LA_MAX'(grpG), srcCin, j);
            end
        end

        for (genvar j = 0; j < GROUPS_PER_STAGE; j++) begin : gGroup
            cla_group #(
                .GROUP(GROUP)
            ) uGroup (
                .a_i   (srcA[k*SW + j*GROUP +: GROUP]),
                .b_i   (srcB[k*SW + j*GROUP +: GROUP]),
                .cin_i (grpC[j]),
                .sum_o (sliceSum[j*GROUP +: GROUP]),
                .p_o   (grpP[j]),
                .g_o   (grpG[j])
            );
        end

        // Lower slices pass through untouched; this stage fills in its own.
        always_comb begin
            nextSum = srcSum;
            nextSum[k*SW +: SW] = sliceSum;
        end

        assign opA_d[k]   = srcA;
        assign opB_d[k]   = srcB;
        assign sum_d[k]   = nextSum;
        assign carry_d[k] = grpC[GROUPS_PER_STAGE];
    end

    // Advance/load chain, walked from the output back to the input: a stage
    // may move when the stage ahead of it is empty or moving this cycle.
    always_comb begin
        logic downstreamFree;
        adv            = '0;
        load           = '0;
        valid_d        = valid_q;
        downstreamFree = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]         = valid_q[k] && downstreamFree;
            downstreamFree = !valid_q[k] || adv[k];
        end
        in_ready = downstreamFree;
        load[0]  = in_valid && downstreamFree;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
                valid_d[k] = 1'b1;
            end else if (adv[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    // Stage registers; data only moves on a load so a stalled stage holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                opA_q[k] <= '0;
                opB_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    opA_q[k]   <= opA_d[k];
                    opB_q[k]   <= opB_d[k];
                    sum_q[k]   <= sum_d[k];
                    carry_q[k] <= carry_d[k];
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_c_out = carry_q[STAGES-1];
    // Overflow when both addends share a sign the sum does not.
    assign out_ovf   = (opA_q[STAGES-1][WIDTH-1] == opB_q[STAGES-1][WIDTH-1]) &&
                       (sum_q[STAGES-1][WIDTH-1] != opA_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_adder
// Directed vectors with hand-computed results; expected results are queued
// on acceptance and a monitor pops and compares whenever a result transfers.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_adder;
    import cla_pkg::*;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam int NVEC   = 16;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             op;
        logic [WIDTH-1:0] sum;
        logic             cOut;
        logic             ovf;
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cOut;
        logic             ovf;
    } res_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_c_in;
    op_e              in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_c_out;
    logic             out_ovf;

    int   checks;
    int   errors;
    vec_t vectors [NVEC];
    res_t scoreboard [$];
    logic stallPrev;
    res_t held;

    pipelined_cla_adder #(
        .WIDTH            (WIDTH),
        .GROUP            (4),
        .GROUPS_PER_STAGE (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c_in   (in_c_in),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_c_out (out_c_out),
        .out_ovf   (out_ovf)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic fillVectors();
        //                a             b             cin   op    sum           cOut  ovf
        vectors[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vectors[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vectors[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vectors[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vectors[4]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
        vectors[5]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vectors[6]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0};
        vectors[7]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vectors[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vectors[9]  = '{32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_000F, 1'b1, 1'b0};
        vectors[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vectors[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vectors[12] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
        vectors[13] = '{32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0, 32'hDFD1_0456, 1'b0, 1'b0};
        vectors[14] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vectors[15] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    endtask

    task automatic driveVector(input vec_t v);
        in_a     = v.a;
        in_b     = v.b;
        in_c_in  = v.cin;
        in_op    = op_e'(v.op);
        in_valid = 1'b1;
    endtask

    task automatic pushExpected(input vec_t v);
        scoreboard.push_back('{v.sum, v.cOut, v.ovf});
    endtask

    // Present one beat and hold it until accepted; returns 1 time unit after
    // the accepting edge with in_valid still high.
    task automatic applyStimulus(input vec_t v, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        driveVector(v);
        while (!done && waits < 100) begin
            @(negedge clk);
            if (in_ready) begin
                pushExpected(v);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("acceptTimeout", done, 1);
    endtask

    task automatic waitDrain(input string name);
        int cyc;
        cyc = 0;
        while (scoreboard.size() != 0 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput(name, scoreboard.size(), 0);
    endtask

    // Scoreboard monitor: a result transfers at the next edge when valid and
    // ready are both high at the falling edge before it.
    always @(negedge clk) begin
        res_t exp;
        if (rst_n && out_valid && out_ready) begin
            checkOutput("resultWasExpected", (scoreboard.size() != 0), 1);
            if (scoreboard.size() != 0) begin
                exp = scoreboard.pop_front();
                checkOutput("sum",  out_sum,   exp.sum);
                checkOutput("cOut", out_c_out, exp.cOut);
                checkOutput("ovf",  out_ovf,   exp.ovf);
            end
        end
    end

    // Output must hold steady while a result waits for the consumer.
    always @(negedge clk) begin
        if (rst_n && stallPrev) begin
            checkOutput("stallValidHeld", out_valid, 1);
            checkOutput("stallDataHeld", {out_sum, out_c_out, out_ovf}, held);
        end
        stallPrev <= rst_n && out_valid && !out_ready;
        held      <= '{out_sum, out_c_out, out_ovf};
    end

    // Hard stop in case something never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waits;
        int totalWaits;
        int latency;
        int accepted;
        int idx;
        int sent;
        int cyc;

        checks    = 0;
        errors    = 0;
        stallPrev = 1'b0;
        held      = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c_in   = 1'b0;
        in_op     = OP_ADD;
        out_ready = 1'b1;
        fillVectors();

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        checkOutput("resetOutValid", out_valid, 0);
        checkOutput("resetOutSum",   out_sum,   0);
        checkOutput("resetOutCOut",  out_c_out, 0);
        checkOutput("resetOutOvf",   out_ovf,   0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("resetInReady", in_ready, 1);
        @(posedge clk);
        #1;

        // Single beat, latency in edges counting the accept edge.
        applyStimulus(vectors[0], waits);
        in_valid = 1'b0;
        latency = 1;
        while (!out_valid && latency < 20) begin
            @(posedge clk);
            #1;
            latency++;
        end
        checkOutput("latencyEdges", latency, STAGES);
        waitDrain("drainLatency");

        // All vectors back to back with the consumer always ready.
        totalWaits = 0;
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vectors[i], waits);
            totalWaits += waits;
        end
        in_valid = 1'b0;
        checkOutput("backToBackWaits", totalWaits, 0);
        waitDrain("drainBackToBack");

        // Consumer stalled for 10 cycles: pipeline fills then refuses input.
        out_ready = 1'b0;
        accepted  = 0;
        idx       = 0;
        for (int c = 0; c < 10; c++) begin
            driveVector(vectors[idx]);
            @(negedge clk);
            if (in_ready) begin
                pushExpected(vectors[idx]);
                accepted++;
                idx++;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("stallAccepted", accepted, STAGES);
        @(negedge clk);
        checkOutput("stallInReady", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain("drainStall");

        // Random valid/ready toggling.
        sent = 0;
        cyc  = 0;
        while (sent < 48 && cyc < 2000) begin
            out_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) != 0) begin
                driveVector(vectors[sent % NVEC]);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                pushExpected(vectors[sent % NVEC]);
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("randomSent", sent, 48);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain("drainRandom");

        // Reset in the middle of a full, stalled pipeline.
        out_ready = 1'b0;
        for (int i = 8; i < 12; i++) begin
            applyStimulus(vectors[i], waits);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("preResetOutValid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midResetOutValid", out_valid, 0);
        checkOutput("midResetOutSum",   out_sum,   0);
        scoreboard.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("postResetOutValid", out_valid, 0);
        checkOutput("postResetInReady",  in_ready,  1);

        // Pipeline still works after the reset.
        applyStimulus(vectors[13], waits);
        in_valid = 1'b0;
        waitDrain("drainAfterReset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
